uart_pixel_packer: RTL and testbench

- Sits between the UART byte receiver and the SDRAM write-port FIFO in the uart-to-SDRAM-to-TFT image path.
- Packs consecutive received bytes, in pairs, into 16-bit RGB565 pixels.
- Presents each pixel, with its linear frame address, on a valid/ready write handshake.
- Counts pixels per frame and raises a sticky display-ready state once a full IMG_H x IMG_V image has been written. The TFT read side waits on this state.

---
 rtl/uart_pixel_packer_if.sv | 13 +
 rtl/uart_pixel_packer.sv | 159 +++++++++++++++
 tb/tb_uart_pixel_packer.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pixel_packer_if.sv
// Pixel write handshake between the packer and the SDRAM write-port FIFO.
// A transfer happens on any clock edge where Wr_en and Wr_ready are both high.
interface uart_pixel_packer_if #(
    parameter int ADDR_W = 16
);
    logic              Wr_en;
    logic [15:0]       Wr_data;
    logic [ADDR_W-1:0] Wr_addr;
    logic              Wr_ready;

    modport master (output Wr_en, Wr_data, Wr_addr, input Wr_ready);
    modport slave  (input Wr_en, Wr_data, Wr_addr, output Wr_ready);
endinterface

// File: rtl/uart_pixel_packer.sv
// Packs UART byte pairs into RGB565 pixels with a linear frame address and
// tracks frame completion for the TFT read side (sticky Disp_state).
module uart_pixel_packer #(
    parameter int IMG_H    = 200,
    parameter int IMG_V    = 5,
    parameter int ADDR_W   = 16,
    parameter int TIMEOUT  = 50000,
    parameter int HI_FIRST = 1
) (
    input  logic                       Clk,
    input  logic                       Rst,
    input  logic [7:0]                 Rx_data,
    input  logic                       Rx_done,
    input  logic                       Disp_clr,
    uart_pixel_packer_if.master        wr,
    output logic                       Frame_done,
    output logic                       Disp_state,
    output logic                       Overflow
);

    localparam int                TMO_W     = $clog2(TIMEOUT + 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_H * IMG_V - 1);
    localparam logic [TMO_W-1:0]  TMO_MAX   = TMO_W'(TIMEOUT);

    typedef enum logic [1:0] {
        S_FIRST  = 2'd0,
        S_SECOND = 2'd1,
        S_PEND   = 2'd2
    } state_e;

    state_e            state_q,      state_d;
    logic [7:0]        byte_q,       byte_d;
    logic [TMO_W-1:0]  tmo_q,        tmo_d;
    logic              wr_en_q,      wr_en_d;
    logic [15:0]       wr_data_q,    wr_data_d;
    logic [ADDR_W-1:0] addr_q,       addr_d;
    logic              clr_pend_q,   clr_pend_d;
    logic              frame_done_q, frame_done_d;
    logic              disp_q,       disp_d;
    logic              ovf_q,        ovf_d;
    logic              xfer;

    assign xfer = (state_q == S_PEND) && wr.Wr_ready;

    always_comb begin
        // NOTE: every _d starts from its _q (or a pulse default) so no path
        // through the case below can leave a signal unassigned and infer a latch.
        state_d      = state_q;
        byte_d       = byte_q;
        tmo_d        = tmo_q;
        wr_data_d    = wr_data_q;
        addr_d       = addr_q;
        clr_pend_d   = clr_pend_q;
        frame_done_d = 1'b0;
        disp_d       = disp_q;
        ovf_d        = ovf_q;

        unique case (state_q)
            S_FIRST: begin
                if (Rx_done) begin
                    byte_d  = Rx_data;
                    tmo_d   = '0;
                    state_d = S_SECOND;
                end
            end

            S_SECOND: begin
                if (Rx_done) begin
                    wr_data_d = (HI_FIRST != 0) ? {byte_q, Rx_data} : {Rx_data, byte_q};
                    state_d   = S_PEND;
                end else begin
                    // The second byte is still accepted on the cycle the count hits TIMEOUT.
                    tmo_d = tmo_q + 1'b1;
                    if (tmo_d == TMO_MAX) begin
                        byte_d  = '0;
                        tmo_d   = '0;
                        state_d = S_FIRST;
                    end
                end
            end

            S_PEND: begin
                if (xfer) begin
                    if (addr_q == LAST_ADDR) begin
                        addr_d       = '0;
                        frame_done_d = 1'b1;
                        disp_d       = 1'b1;
                    end else begin
                        addr_d = addr_q + 1'b1;
                    end
                    if (clr_pend_q) begin
                        addr_d = '0;
                    end
                    clr_pend_d = 1'b0;
                    if (Rx_done) begin
                        byte_d  = Rx_data;
                        tmo_d   = '0;
                        state_d = S_SECOND;
                    end else begin
                        state_d = S_FIRST;
                    end
                end else if (Rx_done) begin
                    ovf_d = 1'b1;
                end
            end

            default: state_d = S_FIRST;
        endcase

        // A pending pixel keeps its address; the restart is deferred past its transfer.
        if (Disp_clr) begin
            disp_d = 1'b0;
            if (state_q != S_PEND) begin
                addr_d = '0;
            end else if (xfer) begin
                addr_d = '0;
            end else begin
                clr_pend_d = 1'b1;
            end
        end

        wr_en_d = (state_d == S_PEND);
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q      <= S_FIRST;
            byte_q       <= '0;
            tmo_q        <= '0;
            wr_en_q      <= 1'b0;
            wr_data_q    <= '0;
            addr_q       <= '0;
            clr_pend_q   <= 1'b0;
            frame_done_q <= 1'b0;
            disp_q       <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so every flop samples the same pre-edge _d values.
            state_q      <= state_d;
            byte_q       <= byte_d;
            tmo_q        <= tmo_d;
            wr_en_q      <= wr_en_d;
            wr_data_q    <= wr_data_d;
            addr_q       <= addr_d;
            clr_pend_q   <= clr_pend_d;
            frame_done_q <= frame_done_d;
            disp_q       <= disp_d;
            ovf_q        <= ovf_d;
        end
    end

    assign wr.Wr_en    = wr_en_q;
    assign wr.Wr_data  = wr_data_q;
    assign wr.Wr_addr  = addr_q;
    assign Frame_done  = frame_done_q;
    assign Disp_state  = disp_q;
    assign Overflow    = ovf_q;

endmodule

// File: tb/tb_uart_pixel_packer.sv
// Scoreboard bench: a pair-packing reference model predicts pixels and flags,
// a negedge monitor compares two DUT instances (HI_FIRST=1 and HI_FIRST=0).
module tb_uart_pixel_packer;

    localparam int IMG_H   = 200;
    localparam int IMG_V   = 5;
    localparam int NPIX    = IMG_H * IMG_V;
    localparam int ADDR_W  = 16;
    localparam int TIMEOUT = 100;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_done = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       disp_clr = 1'b0;
    logic       wr_ready = 1'b1;

    logic fd_hi, disp_hi, ovf_hi;
    logic fd_lo, disp_lo, ovf_lo;

    always #5 clk = ~clk;

    uart_pixel_packer_if #(.ADDR_W(ADDR_W)) bus_hi ();
    uart_pixel_packer_if #(.ADDR_W(ADDR_W)) bus_lo ();
    assign bus_hi.Wr_ready = wr_ready;
    assign bus_lo.Wr_ready = wr_ready;

    uart_pixel_packer #(
        .IMG_H(IMG_H), .IMG_V(IMG_V), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT), .HI_FIRST(1)
    ) dut_hi (
        .Clk(clk), .Rst(rst), .Rx_data(rx_data), .Rx_done(rx_done), .Disp_clr(disp_clr),
        .wr(bus_hi.master), .Frame_done(fd_hi), .Disp_state(disp_hi), .Overflow(ovf_hi)
    );

    uart_pixel_packer #(
        .IMG_H(IMG_H), .IMG_V(IMG_V), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT), .HI_FIRST(0)
    ) dut_lo (
        .Clk(clk), .Rst(rst), .Rx_data(rx_data), .Rx_done(rx_done), .Disp_clr(disp_clr),
        .wr(bus_lo.master), .Frame_done(fd_lo), .Disp_state(disp_lo), .Overflow(ovf_lo)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: pixels are pairs of accepted bytes, each pixel gets the
    // next frame address, a frame is IMG_H*IMG_V pixels.
    bit          m_have = 1'b0;
    logic [7:0]  m_byte = 8'h00;
    int          m_idle = 0;
    bit          m_pend = 1'b0;
    int          m_addr = 0;
    bit          m_clr_after = 1'b0;
    logic [15:0] m_dhi = 16'h0000;
    logic [15:0] m_dlo = 16'h0000;
    bit          m_fd = 1'b0;
    bit          m_disp = 1'b0;
    bit          m_ovf = 1'b0;
    logic [31:0] q_hi[$];
    logic [31:0] q_lo[$];

    always @(posedge clk) begin
        if (rst) begin
            m_have = 0; m_byte = 0; m_idle = 0; m_pend = 0; m_addr = 0; m_clr_after = 0;
            m_dhi = 0; m_dlo = 0; m_fd = 0; m_disp = 0; m_ovf = 0;
            q_hi.delete();
            q_lo.delete();
        end else begin
            m_fd = 0;
            if (m_pend) begin
                if (wr_ready) begin
                    m_pend = 0;
                    if (m_addr == NPIX - 1) begin
                        m_addr = 0;
                        m_fd   = 1;
                        m_disp = 1;
                    end else begin
                        m_addr = m_addr + 1;
                    end
                    if (m_clr_after || disp_clr) m_addr = 0;
                    m_clr_after = 0;
                    if (rx_done) begin
                        m_have = 1; m_byte = rx_data; m_idle = 0;
                    end
                end else begin
                    if (rx_done) m_ovf = 1;
                    if (disp_clr) m_clr_after = 1;
                end
            end else begin
                if (disp_clr) m_addr = 0;
                if (m_have) begin
                    if (rx_done) begin
                        m_dhi = {m_byte, rx_data};
                        m_dlo = {rx_data, m_byte};
                        q_hi.push_back({16'(m_addr), m_dhi});
                        q_lo.push_back({16'(m_addr), m_dlo});
                        m_pend = 1;
                        m_have = 0;
                    end else begin
                        m_idle = m_idle + 1;
                        if (m_idle == TIMEOUT) m_have = 0;
                    end
                end else if (rx_done) begin
                    m_have = 1; m_byte = rx_data; m_idle = 0;
                end
            end
            if (disp_clr) m_disp = 0;
        end
    end

    // Monitor: flags every cycle, transfers against the scoreboard queues.
    int          n_xfer = 0;
    int          fd_count = 0;
    logic [15:0] last_hi = 16'h0000;
    logic [15:0] last_lo = 16'h0000;
    logic [15:0] last_addr = 16'h0000;

    always @(negedge clk) begin
        check("wr_en_hi",   bus_hi.Wr_en,   m_pend);
        check("wr_en_lo",   bus_lo.Wr_en,   m_pend);
        check("wr_addr_hi", bus_hi.Wr_addr, 32'(m_addr));
        check("wr_addr_lo", bus_lo.Wr_addr, 32'(m_addr));
        check("wr_data_hi", bus_hi.Wr_data, m_dhi);
        check("wr_data_lo", bus_lo.Wr_data, m_dlo);
        check("frame_done_hi", fd_hi,   m_fd);
        check("frame_done_lo", fd_lo,   m_fd);
        check("disp_state_hi", disp_hi, m_disp);
        check("disp_state_lo", disp_lo, m_disp);
        check("overflow_hi",   ovf_hi,  m_ovf);
        check("overflow_lo",   ovf_lo,  m_ovf);
        if (fd_hi) fd_count++;
        if (!rst && wr_ready && bus_hi.Wr_en) begin
            n_xfer++;
            last_hi   = bus_hi.Wr_data;
            last_addr = bus_hi.Wr_addr;
            if (q_hi.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL xfer_hi: unexpected pixel 0x%0h at addr %0d", bus_hi.Wr_data, bus_hi.Wr_addr);
            end else begin
                check("xfer_hi", {bus_hi.Wr_addr, bus_hi.Wr_data}, q_hi.pop_front());
            end
        end
        if (!rst && wr_ready && bus_lo.Wr_en) begin
            last_lo = bus_lo.Wr_data;
            if (q_lo.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL xfer_lo: unexpected pixel 0x%0h at addr %0d", bus_lo.Wr_data, bus_lo.Wr_addr);
            end else begin
                check("xfer_lo", {bus_lo.Wr_addr, bus_lo.Wr_data}, q_lo.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input logic [7:0] b);
        rx_data = b;
        rx_done = 1'b1;
        tick();
        rx_done = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    int base_x;
    int base_fd;

    initial begin
        tick();
        tick();
        rst = 1'b0;
        check("reset_wr_en",   bus_hi.Wr_en,   0);
        check("reset_wr_data", bus_hi.Wr_data, 0);
        check("reset_wr_addr", bus_hi.Wr_addr, 0);

        // Basic pair, both byte orders
        base_x = n_xfer;
        send(8'h01); idle(2); send(8'h02); idle(3);
        check("t1_count", n_xfer - base_x, 1);
        check("t1_data_hi", last_hi, 16'h0102);
        check("t1_data_lo", last_lo, 16'h0201);
        check("t1_addr", last_addr, 0);

        // Full frame of incrementing bytes
        do_reset();
        base_x = n_xfer;
        base_fd = fd_count;
        for (int i = 1; i <= 2000; i++) send(8'(i));
        idle(3);
        check("t2_count", n_xfer - base_x, NPIX);
        check("t2_last_data", last_hi, 16'hCFD0);
        check("t2_last_addr", last_addr, NPIX - 1);
        check("t2_frame_done", fd_count - base_fd, 1);
        check("t2_disp", disp_hi, 1);
        check("t2_wrap_addr", bus_hi.Wr_addr, 0);
        send(8'h03); send(8'h04); idle(3);
        check("t2_next_addr", last_addr, 0);

        // Disp_clr while a pixel is pending, then while idle
        wr_ready = 1'b0;
        send(8'h05); send(8'h06); idle(1);
        disp_clr = 1'b1; tick(); disp_clr = 1'b0;
        check("clr_disp", disp_hi, 0);
        check("clr_pend_addr", bus_hi.Wr_addr, 1);
        wr_ready = 1'b1;
        idle(2);
        check("clr_xfer_addr", last_addr, 1);
        check("clr_after_addr", bus_hi.Wr_addr, 0);

        // Orphan byte timeout and the Rx_done-wins boundary
        do_reset();
        base_x = n_xfer;
        send(8'h55); idle(TIMEOUT + 5); send(8'hAA); idle(2); send(8'hBB); idle(3);
        check("t3_count", n_xfer - base_x, 1);
        check("t3_data", last_hi, 16'hAABB);
        check("t3_addr", last_addr, 0);
        send(8'h11); idle(TIMEOUT - 1); send(8'h22); idle(3);
        check("tmo_edge_data", last_hi, 16'h1122);
        send(8'h33); idle(TIMEOUT); send(8'h44); idle(1); send(8'h55); idle(3);
        check("tmo_drop_data", last_hi, 16'h4455);
        check("tmo_count", n_xfer - base_x, 3);

        // Overflow while pending
        do_reset();
        base_x = n_xfer;
        wr_ready = 1'b0;
        send(8'hA1); send(8'hB2); idle(3); send(8'h77); idle(3);
        check("t4_ovf", ovf_hi, 1);
        check("t4_held", bus_hi.Wr_data, 16'hA1B2);
        wr_ready = 1'b1;
        idle(4);
        check("t4_count", n_xfer - base_x, 1);
        check("t4_data", last_hi, 16'hA1B2);

        // Byte arriving on the transfer cycle starts the next pixel
        do_reset();
        base_x = n_xfer;
        wr_ready = 1'b0;
        send(8'hC3); send(8'hD4); idle(2);
        wr_ready = 1'b1;
        send(8'hE5); send(8'hF6); idle(3);
        check("t5_ovf", ovf_hi, 0);
        check("t5_count", n_xfer - base_x, 2);
        check("t5_data", last_hi, 16'hE5F6);

        // Reset mid-pair
        send(8'h99);
        do_reset();
        check("t6_wr_en", bus_hi.Wr_en, 0);
        check("t6_wr_addr", bus_hi.Wr_addr, 0);
        check("t6_ovf", ovf_hi, 0);
        send(8'h12); send(8'h34); idle(3);
        check("t6_data", last_hi, 16'h1234);
        check("t6_addr", last_addr, 0);

        // Randomized traffic, back-pressure and occasional Disp_clr
        do_reset();
        for (int i = 0; i < 6000; i++) begin
            rx_done  = ($urandom_range(99) < 60);
            rx_data  = 8'($urandom);
            wr_ready = ($urandom_range(99) < 75);
            disp_clr = ($urandom_range(999) < 3);
            tick();
        end
        rx_done = 1'b0;
        disp_clr = 1'b0;
        wr_ready = 1'b1;
        idle(5);
        check("drain_hi", q_hi.size(), 0);
        check("drain_lo", q_lo.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
